// File: rtl/vexec_pkg.sv
// rtl/vexec_pkg.sv - opcode encoding and lane helpers shared by the vector execute pipe
package vexec_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_ADDS  = 3'd2,
    OP_SUBS  = 3'd3,
    OP_MUL   = 3'd4,
    OP_BLEND = 3'd5,
    OP_MIN   = 3'd6,
    OP_MAX   = 3'd7
  } op_e;

  // Largest unsigned value of a w-bit lane (w up to 32).
  function automatic logic [31:0] lane_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/vexec_lane.sv
// rtl/vexec_lane.sv - one lane of the two-stage vector ALU datapath
module vexec_lane
  import vexec_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en1,
  input  logic         en2,
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] res,
  output logic         zero,
  output logic         sat
);

  localparam logic [W-1:0] M = W'(lane_max(W));

  op_e            op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W-1:0] pab_q, pab_d, pac_q, pac_d, pbc_q, pbc_d;
  logic [W-1:0]   res_q, res_d, res_n;
  logic           zero_q, zero_d, sat_q, sat_d, sat_n;
  logic [W:0]     sum, diff;
  logic [2*W-1:0] blend;

  // Stage 1 captures operands and all three full-width products.
  always_comb begin
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    pab_d = pab_q;
    pac_d = pac_q;
    pbc_d = pbc_q;
    if (en1) begin
      op_d  = op;
      a_d   = a;
      b_d   = b;
      pab_d = (2*W)'(a) * (2*W)'(b);
      pac_d = (2*W)'(a) * (2*W)'(c);
      pbc_d = (2*W)'(b) * (2*W)'(M - c);
    end
  end

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    blend = pac_q + pbc_q;
    res_n = '0;
    sat_n = 1'b0;
    case (op_q)
      OP_ADD:   res_n = sum[W-1:0];
      OP_SUB:   res_n = diff[W-1:0];
      OP_ADDS: begin
        sat_n = sum[W];
        res_n = sum[W] ? M : sum[W-1:0];
      end
      OP_SUBS: begin
        sat_n = diff[W];
        res_n = diff[W] ? '0 : diff[W-1:0];
      end
      OP_MUL:   res_n = pab_q[2*W-1:W];
      OP_BLEND: res_n = blend[2*W-1:W];
      OP_MIN:   res_n = (a_q < b_q) ? a_q : b_q;
      default:  res_n = (a_q > b_q) ? a_q : b_q;
    endcase
    res_d  = en2 ? res_n : res_q;
    sat_d  = en2 ? sat_n : sat_q;
    zero_d = en2 ? (res_n == '0) : zero_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      pab_q  <= '0;
      pac_q  <= '0;
      pbc_q  <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      pab_q  <= pab_d;
      pac_q  <= pac_d;
      pbc_q  <= pbc_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      sat_q  <= sat_d;
    end
  end

  assign res  = res_q;
  assign zero = zero_q;
  assign sat  = sat_q;

endmodule

// File: rtl/vexec_pipe.sv
// rtl/vexec_pipe.sv - two-stage pipelined vector ALU with valid/ready, flush and tag tracking
module vexec_pipe
  import vexec_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int LANE_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  input  logic [LANES*LANE_W-1:0] in_c,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_zero,
  output logic                    out_sat,
  output logic                    s1_valid,
  output logic [TAG_W-1:0]        s1_tag
);

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic             s2_ready, s1_ready, accept, advance;
  logic [LANES-1:0] lane_zero, lane_sat;

  // Stage 1 may advance into an empty stage 2 even while the consumer stalls.
  always_comb begin
    s2_ready = !v2_q || out_ready;
    s1_ready = !v1_q || s2_ready;
    in_ready = rst && s1_ready && !flush;
    accept   = in_valid && in_ready;
    advance  = v1_q && s2_ready && !flush;
    v1_d     = v1_q;
    v2_d     = v2_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (advance)        v2_d = 1'b1;
      else if (out_ready) v2_d = 1'b0;
      if (accept)         v1_d = 1'b1;
      else if (advance)   v1_d = 1'b0;
    end
    tag1_d = accept  ? in_tag : tag1_q;
    tag2_d = advance ? tag1_q : tag2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vexec_lane #(.W(LANE_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .en1 (accept),
      .en2 (advance),
      .op  (op_e'(in_op)),
      .a   (in_a[l*LANE_W +: LANE_W]),
      .b   (in_b[l*LANE_W +: LANE_W]),
      .c   (in_c[l*LANE_W +: LANE_W]),
      .res (out_data[l*LANE_W +: LANE_W]),
      .zero(lane_zero[l]),
      .sat (lane_sat[l])
    );
  end

  assign out_valid = v2_q;
  assign out_tag   = tag2_q;
  assign out_zero  = &lane_zero;
  assign out_sat   = |lane_sat;
  assign s1_valid  = v1_q;
  assign s1_tag    = tag1_q;

endmodule
